// File: rtl/banked_regfile_pkg.sv
// Shared types and helpers for the banked register file: write-size encoding
// and byte/half/word extension. Widths up to MAX_WIDTH are supported.
package banked_regfile_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BYTE = 2'b01,
    HALF = 2'b10,
    WORD = 2'b11
  } write_size_e;

  // Callers truncate the result to their register width; the fill bits are
  // uniform, so truncation never changes the extended value.
  function automatic logic [MAX_WIDTH-1:0] extend_write(
    input write_size_e          size,
    input logic                 sext,
    input logic [MAX_WIDTH-1:0] data
  );
    logic [MAX_WIDTH-1:0] result;
    case (size)
      BYTE:    result = {{(MAX_WIDTH-8){sext & data[7]}}, data[7:0]};
      HALF:    result = {{(MAX_WIDTH-16){sext & data[15]}}, data[15:0]};
      default: result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/banked_regfile_scoreboard.sv
// Pending-write tracker: one busy bit per user register plus one for the
// supervisor stack pointer. A lock beats a write to the same entry.
module regfile_scoreboard #(
  parameter int IDXW    = 5,
  parameter int ENTRIES = 17
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lock_en,
  input  logic [IDXW-1:0]    lock_idx,
  input  logic               write_hit,
  input  logic [IDXW-1:0]    write_idx,
  output logic [ENTRIES-1:0] busy
);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (lock_en && lock_idx == IDXW'(i)) begin
          busy[i] <= 1'b1;
        end else if (write_hit && write_idx == IDXW'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/banked_regfile.sv
// Register file with a banked supervisor stack pointer and per-register
// pending-write tracking. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module banked_regfile
  import banked_regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int COUNT  = 16,
  parameter int COUNTP = 4,
  parameter int NREAD  = 2,
  parameter int SPREG  = COUNT - 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    supervisor,
  input  logic [NREAD*COUNTP-1:0] read_addr,
  output logic [NREAD*WIDTH-1:0]  read_data,
  output logic [NREAD-1:0]        read_busy,
  input  logic [COUNTP-1:0]       write_addr,
  input  logic [WIDTH-1:0]        write_data,
  input  logic [1:0]              write_en,
  input  logic                    write_sext,
  input  logic                    lock_en,
  input  logic [COUNTP-1:0]       lock_addr,
  output logic [WIDTH-1:0]        ssp_o
);

  // Resolved index space: 0..COUNT-1 are user registers, COUNT is ssp.
  localparam int                IDXW    = COUNTP + 1;
  localparam logic [COUNTP-1:0] SP_ADDR = COUNTP'(SPREG);
  localparam logic [IDXW-1:0]   SSP_IDX = IDXW'(COUNT);

  if (WIDTH < 16 || WIDTH > MAX_WIDTH || (2 ** COUNTP) != COUNT ||
      SPREG < 0 || SPREG >= COUNT) begin : g_param_check
    $error("banked_regfile: illegal parameter combination");
  end

  function automatic logic [IDXW-1:0] resolve(
    input logic [COUNTP-1:0] addr,
    input logic              sup
  );
    return (sup && addr == SP_ADDR) ? SSP_IDX : {1'b0, addr};
  endfunction

  logic [WIDTH-1:0] regs [COUNT+1];
  logic [COUNT:0]   busy;
  logic             wr_active;
  write_size_e      wr_size;
  logic [IDXW-1:0]  wr_idx;
  logic [IDXW-1:0]  lk_idx;
  logic [WIDTH-1:0] wr_value;

  assign wr_size   = write_size_e'(write_en);
  assign wr_active = (wr_size != NONE);
  assign wr_idx    = resolve(write_addr, supervisor);
  assign lk_idx    = resolve(lock_addr, supervisor);
  assign wr_value  = WIDTH'(extend_write(wr_size, write_sext, MAX_WIDTH'(write_data)));
  assign ssp_o     = regs[COUNT];

  // NOTE: the storage array is reset explicitly because cleared registers are
  // architecturally visible; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < COUNT + 1; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[wr_idx] <= wr_value;
    end
  end

  regfile_scoreboard #(
    .IDXW    (IDXW),
    .ENTRIES (COUNT + 1)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .lock_en   (lock_en),
    .lock_idx  (lk_idx),
    .write_hit (wr_active),
    .write_idx (wr_idx),
    .busy      (busy)
  );

  // NOTE: every output of this block gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [IDXW-1:0] ridx;
    ridx      = '0;
    read_data = '0;
    read_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      ridx = resolve(read_addr[k*COUNTP +: COUNTP], supervisor);
      read_data[k*WIDTH +: WIDTH] = regs[ridx];
      read_busy[k]                = busy[ridx];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle lock of the write target still reports busy.
      if (wr_active && ridx == wr_idx) begin
        read_data[k*WIDTH +: WIDTH] = wr_value;
        read_busy[k]                = lock_en && (lk_idx == wr_idx);
      end
`endif
    end
  end

endmodule
